arch_state_dumper: RTL and testbench
====================================

Name: arch_state_dumper

Overview:
Synthesizable run-control and architectural-state readout block for the O3O CPU.
- Counts run cycles and detects completion (done) or timeout.
- Then walks the front RAT, reading the PRF through each mapping, and streams the architectural register file out over a valid/ready channel, NUM_LANES registers per beat.
- Sits beside the CPU core. It replaces bench-side cycle limiting and state printing, so the same dump works on FPGA or a debug port.

Parameters:
DATA_WIDTH, 32, width of one register value
PHY_REGS, 64, number of physical registers
PHY_WIDTH, 6, physical register index width (clog2 PHY_REGS)
ARCH_REGS, 32, number of architectural registers; must be a multiple of NUM_LANES
NUM_LANES, 1, registers emitted per beat (1, 2, 4 or 8)
CYCLE_WIDTH, 16, width of the cycle counter and timeout limit
ZERO_X0, 1, when 1, lane data for architectural index 0 is forced to 0

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
done_i  in  1  CPU completion indication
max_cycles_i  in  CYCLE_WIDTH  timeout limit; 0 disables timeout
prf_data_i  in  PHY_REGS*DATA_WIDTH  flat PRF; entry i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
prf_valid_i  in  PHY_REGS  PRF valid bits
front_rat_i  in  PHY_WIDTH*ARCH_REGS  flat front RAT; entry i at [i*PHY_WIDTH +: PHY_WIDTH]
dump_valid_o  out  1  beat valid
dump_ready_i  in  1  consumer ready
dump_idx_o  out  clog2(ARCH_REGS)  architectural index of lane 0
dump_data_o  out  NUM_LANES*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH], arch index dump_idx_o+k
dump_pending_o  out  NUM_LANES  lane k's mapped PRF entry not valid
dump_last_o  out  1  current beat is the final beat
cycle_count_o  out  CYCLE_WIDTH  cycles spent in RUN
timeout_o  out  1  dump was triggered by timeout
finished_o  out  1  dump complete (sticky)
state_o  out  2  0 RUN, 1 DUMP, 2 DONE

Behaviour:
Reset (async, immediate):
- state RUN; cycle_count_o 0; all other outputs 0.
- Reset mid-DUMP aborts the stream. dump_valid_o drops at once.

RUN state, evaluated each rising edge:
- cycle_count_o increments by 1 and saturates at all-ones; no wrap.
- If done_i is high, go to DUMP with timeout_o=0. The counter does not increment on this edge.
- Else, if max_cycles_i != 0 and cycle_count_o+1 == max_cycles_i, go to DUMP with timeout_o=1. The counter takes the value max_cycles_i.
- If done_i and the timeout condition occur on the same edge, done wins and timeout_o=0.
- Once RUN is left, cycle_count_o and timeout_o hold until reset.

Beat loading:
- The edge that enters DUMP also loads beat 0: dump_idx_o=0, dump_valid_o=1.
- Lane k data = prf[front_rat[idx+k]], captured from the live inputs at the load edge.
- Lane k pending = ~prf_valid_i[front_rat[idx+k]], captured at the same edge.
- When ZERO_X0=1, lane data for architectural index 0 is 0 and its pending bit is 0.
- Beat data, idx and pending are registered and stay stable while dump_valid_o && !dump_ready_i. Later input changes do not affect a held beat.

Handshake:
- A transfer occurs on a rising edge with dump_valid_o && dump_ready_i.
- On a transfer of a non-last beat, the next beat is loaded on the same edge: idx += NUM_LANES. dump_valid_o stays 1, giving back-to-back beats with no bubble.
- dump_last_o = (dump_idx_o == ARCH_REGS-NUM_LANES) && dump_valid_o.
- On transfer of the last beat: go to DONE, dump_valid_o=0, finished_o=1.
- dump_valid_o never drops without a transfer, except on reset.
- dump_ready_i is ignored outside DUMP.
- Number of beats = ARCH_REGS/NUM_LANES.

DONE state:
- Sticky until reset.
- done_i and max_cycles_i are ignored.
- finished_o stays 1.

Out-of-range RAT entries (>= PHY_REGS) read data 0 with pending 1.

Latency:
- done_i sampled high at edge N gives dump_valid_o high after edge N.
- With dump_ready_i held at 1, finished_o rises after edge N + ARCH_REGS/NUM_LANES.

Test Plan:
1. Lanes=1, RAT[i]=i, prf[i]=0x1000+i, all valid. done_i pulsed on cycle 10 with ready=1 -> cycle_count_o=10; 32 beats idx 0..31 with data 0x1000+i, except idx0=0. dump_last_o is set on idx31 only. finished_o rises 32 cycles after done_i. timeout_o=0.
2. max_cycles_i=25, done_i never asserted -> DUMP is entered with cycle_count_o=25 and timeout_o=1. The counter is frozen afterwards.
3. done_i and the timeout condition on the same edge (max_cycles_i=8, done_i high on cycle 8) -> timeout_o=0 and the dump proceeds normally.
4. Backpressure: ready toggles 1,0,0,1 repeatedly while prf/RAT are changed during stalls -> each held beat keeps its captured values. There are no duplicated or skipped indices, and the beat count stays 32.
5. NUM_LANES=4, RAT[5]=40 with prf_valid[40]=0, prf[40]=0xDEAD -> beat idx4 has lane1=0xDEAD and dump_pending_o=4'b0010. There are 8 beats in total.
6. rst asserted mid-dump at beat 12 -> outputs clear asynchronously. After release, the block is in RUN with count 0, and a new done_i restarts the dump from idx 0.

Source files
------------

// File: rtl/arch_state_dumper.sv
// Run-control and architectural register readout: counts RUN cycles, stops on done or timeout,
// then streams prf[front_rat[i]] for every architectural register over a valid/ready channel.
module arch_state_dumper #(
    parameter int DATA_WIDTH  = 32,
    parameter int PHY_REGS    = 64,
    parameter int PHY_WIDTH   = 6,
    parameter int ARCH_REGS   = 32,
    parameter int NUM_LANES   = 1,
    parameter int CYCLE_WIDTH = 16,
    parameter int ZERO_X0     = 1,
    localparam int IDX_W      = $clog2(ARCH_REGS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            done_i,
    input  logic [CYCLE_WIDTH-1:0]          max_cycles_i,
    input  logic [PHY_REGS*DATA_WIDTH-1:0]  prf_data_i,
    input  logic [PHY_REGS-1:0]             prf_valid_i,
    input  logic [PHY_WIDTH*ARCH_REGS-1:0]  front_rat_i,
    output logic                            dump_valid_o,
    input  logic                            dump_ready_i,
    output logic [IDX_W-1:0]                dump_idx_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0] dump_data_o,
    output logic [NUM_LANES-1:0]            dump_pending_o,
    output logic                            dump_last_o,
    output logic [CYCLE_WIDTH-1:0]          cycle_count_o,
    output logic                            timeout_o,
    output logic                            finished_o,
    output logic [1:0]                      state_o
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_DUMP = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(ARCH_REGS - NUM_LANES);
    localparam logic [IDX_W-1:0]       LANE_STEP = IDX_W'(NUM_LANES);
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_MAX = '1;

    logic [1:0]                      state_q, state_d;
    logic [CYCLE_WIDTH-1:0]          cycle_q, cycle_d;
    logic                            timeout_q, timeout_d;
    logic                            finished_q, finished_d;
    logic                            valid_q, valid_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_LANES-1:0]            pend_q, pend_d;

    logic [IDX_W-1:0]                load_idx;
    logic [NUM_LANES*DATA_WIDTH-1:0] load_data;
    logic [NUM_LANES-1:0]            load_pend;
    logic [CYCLE_WIDTH:0]            cycle_inc;

    // Beat 0 is loaded on the edge leaving RUN; later beats follow the one being transferred.
    assign load_idx  = (state_q == ST_RUN) ? '0 : idx_q + LANE_STEP;
    assign cycle_inc = {1'b0, cycle_q} + 1'b1;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [IDX_W-1:0]      arch_idx;
        logic [PHY_WIDTH-1:0]  phy_idx;
        logic [DATA_WIDTH-1:0] lane_data;
        logic                  lane_pend;

        assign arch_idx = load_idx + IDX_W'(k);
        assign phy_idx  = front_rat_i[arch_idx*PHY_WIDTH +: PHY_WIDTH];

        // Unmapped physical indices read as pending zero so a corrupt RAT is visible in the dump.
        always_comb begin
            lane_data = '0;
            lane_pend = 1'b1;
            if (ZERO_X0 != 0 && arch_idx == '0) begin
                lane_pend = 1'b0;
            end else if (int'(phy_idx) < PHY_REGS) begin
                lane_data = prf_data_i[phy_idx*DATA_WIDTH +: DATA_WIDTH];
                lane_pend = ~prf_valid_i[phy_idx];
            end
        end

        assign load_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_data;
        assign load_pend[k] = lane_pend;
    end

    // Stream: a beat moves on any edge with valid && ready; valid only falls after the last
    // transfer, and idx/data/pending are frozen while valid && !ready.
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        timeout_d  = timeout_q;
        finished_d = finished_q;
        valid_d    = valid_q;
        idx_d      = idx_q;
        data_d     = data_q;
        pend_d     = pend_q;
        case (state_q)
            ST_RUN: begin
                if (done_i) begin
                    state_d   = ST_DUMP;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    idx_d     = load_idx;
                    data_d    = load_data;
                    pend_d    = load_pend;
                end else if (max_cycles_i != '0 && cycle_inc == {1'b0, max_cycles_i}) begin
                    state_d   = ST_DUMP;
                    timeout_d = 1'b1;
                    cycle_d   = max_cycles_i;
                    valid_d   = 1'b1;
                    idx_d     = load_idx;
                    data_d    = load_data;
                    pend_d    = load_pend;
                end else if (cycle_q != CYCLE_MAX) begin
                    cycle_d = cycle_inc[CYCLE_WIDTH-1:0];
                end
            end
            ST_DUMP: begin
                if (valid_q && dump_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_DONE;
                        valid_d    = 1'b0;
                        finished_d = 1'b1;
                    end else begin
                        idx_d  = load_idx;
                        data_d = load_data;
                        pend_d = load_pend;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cycle_q    <= '0;
            timeout_q  <= 1'b0;
            finished_q <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            timeout_q  <= timeout_d;
            finished_q <= finished_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            pend_q     <= pend_d;
        end
    end

    assign dump_valid_o   = valid_q;
    assign dump_idx_o     = idx_q;
    assign dump_data_o    = data_q;
    assign dump_pending_o = pend_q;
    assign dump_last_o    = valid_q && (idx_q == LAST_IDX);
    assign cycle_count_o  = cycle_q;
    assign timeout_o      = timeout_q;
    assign finished_o     = finished_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_arch_state_dumper.sv
// Bench for arch_state_dumper: one-lane and four-lane instances share stimulus and are
// checked every cycle against a register-file level model with expected-index queues.
module tb_arch_state_dumper;

    localparam int CW = 8;

    logic              clk, rst, done_i, dump_ready_i;
    logic [CW-1:0]     max_cycles_i;
    logic [64*32-1:0]  prf_data_i;
    logic [63:0]       prf_valid_i;
    logic [6*32-1:0]   front_rat_i;

    logic        o1_valid, o1_last, o1_timeout, o1_fin;
    logic [4:0]  o1_idx;
    logic [31:0] o1_data;
    logic [0:0]  o1_pend;
    logic [CW-1:0] o1_count;
    logic [1:0]  o1_state;

    logic        o4_valid, o4_last, o4_timeout, o4_fin;
    logic [4:0]  o4_idx;
    logic [127:0] o4_data;
    logic [3:0]  o4_pend;
    logic [CW-1:0] o4_count;
    logic [1:0]  o4_state;

    arch_state_dumper #(.NUM_LANES(1), .CYCLE_WIDTH(CW)) u_dut1 (
        .clk(clk), .rst(rst), .done_i(done_i), .max_cycles_i(max_cycles_i),
        .prf_data_i(prf_data_i), .prf_valid_i(prf_valid_i), .front_rat_i(front_rat_i),
        .dump_valid_o(o1_valid), .dump_ready_i(dump_ready_i), .dump_idx_o(o1_idx),
        .dump_data_o(o1_data), .dump_pending_o(o1_pend), .dump_last_o(o1_last),
        .cycle_count_o(o1_count), .timeout_o(o1_timeout), .finished_o(o1_fin), .state_o(o1_state)
    );

    arch_state_dumper #(.NUM_LANES(4), .CYCLE_WIDTH(CW)) u_dut4 (
        .clk(clk), .rst(rst), .done_i(done_i), .max_cycles_i(max_cycles_i),
        .prf_data_i(prf_data_i), .prf_valid_i(prf_valid_i), .front_rat_i(front_rat_i),
        .dump_valid_o(o4_valid), .dump_ready_i(dump_ready_i), .dump_idx_o(o4_idx),
        .dump_data_o(o4_data), .dump_pending_o(o4_pend), .dump_last_o(o4_last),
        .cycle_count_o(o4_count), .timeout_o(o4_timeout), .finished_o(o4_fin), .state_o(o4_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] prf[64];
    bit          pv[64];
    int          rat[32];

    int           m_state[2], m_count[2], m_idx[2], obs_beats[2];
    bit           m_timeout[2], m_finished[2], m_valid[2];
    logic [127:0] m_data[2];
    logic [7:0]   m_pend[2];
    logic [4:0]   exp_q0[$];
    logic [4:0]   exp_q1[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lanes_of(input int n);
        return (n == 0) ? 1 : 4;
    endfunction

    function automatic string pfx(input int n);
        return (n == 0) ? "L1" : "L4";
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_state[n] = 0; m_count[n] = 0; m_idx[n] = 0; obs_beats[n] = 0;
            m_timeout[n] = 0; m_finished[n] = 0; m_valid[n] = 0;
            m_data[n] = '0; m_pend[n] = '0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Architectural register a as the dump should present it.
    task automatic model_load(input int n, input int base);
        m_idx[n] = base;
        m_valid[n] = 1;
        m_data[n] = '0;
        m_pend[n] = '0;
        for (int k = 0; k < lanes_of(n); k++) begin
            if (base + k != 0) begin
                m_data[n][k*32 +: 32] = prf[rat[base+k]];
                m_pend[n][k] = !pv[rat[base+k]];
            end
        end
        if (n == 0) exp_q0.push_back(5'(base));
        else        exp_q1.push_back(5'(base));
    endtask

    task automatic model_step(input int n, input bit d, input bit r);
        if (m_state[n] == 0) begin
            if (d) begin
                m_state[n] = 1; m_timeout[n] = 0; model_load(n, 0);
            end else if (max_cycles_i != 0 && m_count[n] + 1 == int'(max_cycles_i)) begin
                m_state[n] = 1; m_timeout[n] = 1; m_count[n] = int'(max_cycles_i); model_load(n, 0);
            end else if (m_count[n] < (1 << CW) - 1) begin
                m_count[n]++;
            end
        end else if (m_state[n] == 1 && r) begin
            if (m_idx[n] == 32 - lanes_of(n)) begin
                m_state[n] = 2; m_valid[n] = 0; m_finished[n] = 1;
                check_val({pfx(n), "_beats"}, 128'(obs_beats[n]), 128'(32 / lanes_of(n)));
            end else begin
                model_load(n, m_idx[n] + lanes_of(n));
            end
        end
    endtask

    task automatic sample(input int n, output logic v, output logic [4:0] ix,
                          output logic [127:0] dt, output logic [7:0] pd, output logic ls,
                          output logic [CW-1:0] cn, output logic to, output logic fn,
                          output logic [1:0] st);
        if (n == 0) begin
            v = o1_valid; ix = o1_idx; dt = {96'b0, o1_data}; pd = {7'b0, o1_pend}; ls = o1_last;
            cn = o1_count; to = o1_timeout; fn = o1_fin; st = o1_state;
        end else begin
            v = o4_valid; ix = o4_idx; dt = o4_data; pd = {4'b0, o4_pend}; ls = o4_last;
            cn = o4_count; to = o4_timeout; fn = o4_fin; st = o4_state;
        end
    endtask

    task automatic check_outputs();
        logic v, ls, to, fn;
        logic [4:0] ix;
        logic [127:0] dt;
        logic [7:0] pd;
        logic [CW-1:0] cn;
        logic [1:0] st;
        for (int n = 0; n < 2; n++) begin
            sample(n, v, ix, dt, pd, ls, cn, to, fn, st);
            check_val({pfx(n), "_state"}, 128'(st), 128'(m_state[n]));
            check_val({pfx(n), "_valid"}, 128'(v), 128'(m_valid[n]));
            check_val({pfx(n), "_count"}, 128'(cn), 128'(m_count[n]));
            check_val({pfx(n), "_timeout"}, 128'(to), 128'(m_timeout[n]));
            check_val({pfx(n), "_finished"}, 128'(fn), 128'(m_finished[n]));
            check_val({pfx(n), "_last"}, 128'(ls),
                      128'(m_valid[n] && m_idx[n] == 32 - lanes_of(n)));
            if (m_valid[n]) begin
                check_val({pfx(n), "_idx"}, 128'(ix), 128'(m_idx[n]));
                check_val({pfx(n), "_data"}, dt, m_data[n]);
                check_val({pfx(n), "_pending"}, 128'(pd), 128'(m_pend[n]));
            end
        end
    endtask

    // Scoreboard: every observed transfer must match the next expected index.
    task automatic observe_transfers();
        logic [4:0] e;
        if (o1_valid && dump_ready_i) begin
            obs_beats[0]++;
            check_val("L1_qsize", 128'(exp_q0.size()), 128'(1));
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check_val("L1_seq_idx", 128'(o1_idx), 128'(e));
            end
        end
        if (o4_valid && dump_ready_i) begin
            obs_beats[1]++;
            check_val("L4_qsize", 128'(exp_q1.size()), 128'(1));
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check_val("L4_seq_idx", 128'(o4_idx), 128'(e));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pack_inputs();
        for (int i = 0; i < 64; i++) begin
            prf_data_i[i*32 +: 32] = prf[i];
            prf_valid_i[i] = pv[i];
        end
        for (int i = 0; i < 32; i++) front_rat_i[i*6 +: 6] = 6'(rat[i]);
    endtask

    task automatic identity_arrays();
        for (int i = 0; i < 64; i++) begin
            prf[i] = 32'h1000 + 32'(i);
            pv[i] = 1;
        end
        for (int i = 0; i < 32; i++) rat[i] = i;
    endtask

    task automatic random_arrays();
        for (int i = 0; i < 64; i++) begin
            prf[i] = $urandom;
            pv[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 32; i++) rat[i] = $urandom_range(0, 63);
    endtask

    // Called at a falling edge: check, drive, advance the model, move to the next falling edge.
    task automatic tick(input bit d, input bit r);
        check_outputs();
        done_i = d;
        dump_ready_i = r;
        pack_inputs();
        observe_transfers();
        model_step(0, d, r);
        model_step(1, d, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_val("rst_idx", 128'({o1_idx, o4_idx}), 128'(0));
        check_val("rst_data", {o4_data[95:0], o1_data}, 128'(0));
        check_val("rst_pend", 128'({o1_pend, o4_pend}), 128'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: ready held, 1: ready 1,0,0,1 with inputs scrambled on stalls, 2: random ready.
    task automatic run_dump(input int mode, input int budget);
        bit r;
        int c;
        c = 0;
        while (!(o1_fin && o4_fin) && c < budget) begin
            case (mode)
                0: r = 1;
                1: r = (c % 4 == 0) || (c % 4 == 3);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            if ((mode == 1 && !r) || (mode == 2 && $urandom_range(0, 1) == 1)) random_arrays();
            tick(0, r);
            c++;
        end
        check_val("L1_finish", 128'(o1_fin), 128'(1));
        check_val("L4_finish", 128'(o4_fin), 128'(1));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int  c, dt;
        bit  hit;
        rst = 1'b1; done_i = 0; dump_ready_i = 0; max_cycles_i = '0;
        prf_data_i = '0; prf_valid_i = '0; front_rat_i = '0;
        identity_arrays();
        pack_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Done after ten RUN cycles, consumer always ready.
        max_cycles_i = 0;
        repeat (10) tick(0, 1);
        tick(1, 1);
        check_val("s1_count", 128'(o1_count), 128'(10));
        c = 0;
        while (!o1_fin && c < 100) begin
            tick(0, 1);
            c++;
        end
        check_val("s1_latency", 128'(c), 128'(32));
        check_val("s1_timeout", 128'(o1_timeout), 128'(0));
        repeat (3) tick(1, 1);

        // Timeout at 25.
        do_reset();
        max_cycles_i = 8'd25;
        c = 0;
        while (o1_state != 2'd1 && c < 40) begin
            tick(0, 0);
            c++;
        end
        check_val("s2_count", 128'(o1_count), 128'(25));
        check_val("s2_timeout", 128'(o1_timeout), 128'(1));
        run_dump(0, 100);
        check_val("s2_count_frozen", 128'(o1_count), 128'(25));

        // Done and timeout on the same edge.
        do_reset();
        max_cycles_i = 8'd8;
        repeat (7) tick(0, 0);
        tick(1, 0);
        check_val("s3_timeout", 128'(o1_timeout), 128'(0));
        check_val("s3_state", 128'(o1_state), 128'(1));
        run_dump(0, 100);

        // Backpressure with inputs changing under held beats.
        do_reset();
        max_cycles_i = 0;
        random_arrays();
        repeat (3) tick(0, 0);
        tick(1, 0);
        run_dump(1, 300);

        // Four-lane pending lane.
        do_reset();
        identity_arrays();
        rat[5] = 40; pv[40] = 0; prf[40] = 32'hDEAD;
        tick(1, 1);
        hit = 0;
        c = 0;
        while (!o4_fin && c < 50) begin
            if (o4_valid && o4_idx == 5'd4) begin
                check_val("s5_lane1", 128'(o4_data[63:32]), 128'(32'hDEAD));
                check_val("s5_pending", 128'(o4_pend), 128'(4'b0010));
                hit = 1;
            end
            tick(0, 1);
            c++;
        end
        check_val("s5_saw_idx4", 128'(hit), 128'(1));
        run_dump(0, 100);

        // Reset in the middle of a dump, then restart.
        do_reset();
        identity_arrays();
        tick(1, 1);
        c = 0;
        while (!(o1_valid && o1_idx == 5'd12) && c < 40) begin
            tick(0, 1);
            c++;
        end
        check_val("s6_reached_12", 128'(o1_idx), 128'(12));
        do_reset();
        repeat (3) tick(0, 0);
        tick(1, 1);
        run_dump(0, 100);

        // Counter saturation.
        do_reset();
        max_cycles_i = 0;
        repeat (260) tick(0, 0);
        check_val("sat_count", 128'(o1_count), 128'(255));
        tick(1, 0);
        run_dump(0, 100);

        // Randomized runs.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            random_arrays();
            max_cycles_i = CW'($urandom_range(0, 40));
            dt = $urandom_range(0, 60);
            if (it == 1) begin
                max_cycles_i = CW'($urandom_range(5, 40));
                dt = 1000;
            end
            c = 0;
            while (o1_state == 2'd0 && c < 200) begin
                if ($urandom_range(0, 1) == 1) random_arrays();
                tick(c == dt, $urandom_range(0, 1) == 1);
                c++;
            end
            run_dump(2, 400);
            repeat (2) tick(1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
